issue_queue_int: RTL and testbench
==================================

Name: issue_queue_int

Overview:
- Integer reservation station/issue queue directly upstream of the integer ALU issue stage.
- Accepts renamed integer ops from dispatch and holds them until both source operands are available, snooping the common data bus (CDB) for tag matches.
- Selects the oldest ready entry and drives the ALU's opcode/rsdata/rtdata/rdtag inputs through a registered valid/ready output stage.
- A flush input discards all in-flight work on branch mispredict.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 6, physical/ROB tag width.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries and the output register
- disp_valid  in  1  dispatch offers an op
- disp_ready  out  1  queue can accept (not full)
- disp_opcode  in  4  ALU opcode (ADD=0000 … STLU=1011)
- disp_rs_rdy  in  1  rs operand value valid
- disp_rs_tag  in  TAG_W  producer tag for rs when not ready
- disp_rs_data  in  DATA_W  rs value when ready
- disp_rt_rdy, disp_rt_tag, disp_rt_data  in  1/TAG_W/DATA_W  same for rt
- disp_rd_tag  in  TAG_W  destination tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast value
- iss_valid  out  1  output register holds an op
- iss_ready  in  1  ALU stage accepts this cycle
- iss_opcode  out  4  to ALU opcode
- iss_rsdata, iss_rtdata  out  DATA_W  to ALU operands
- iss_rdtag  out  TAG_W  to ALU rdtag
- iq_count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset or flush: all entry valid bits=0; iss_valid=0; iss_opcode/iss_rsdata/iss_rtdata/iss_rdtag=0; iq_count=0; disp_ready=1 the next cycle. Flush has priority over a same-cycle dispatch, CDB capture and issue; none take effect.
- Storage: compacting array; entry 0 is oldest. Each entry holds valid, opcode, rd_tag, and per source {rdy, tag, data}.
- Dispatch: accepted on an edge where disp_valid && disp_ready. Written at the lowest free index after compaction. disp_ready = (iq_count < DEPTH), registered-state only, with no dependency on same-cycle issue.
- Dispatch-time wakeup: if a source is not ready and cdb_valid && cdb_tag == source tag in the dispatch cycle, the entry is written with rdy=1 and data=cdb_data.
- CDB snoop: every valid entry source with rdy=0 and a matching tag captures cdb_data and sets rdy=1 on that edge. Both rs and rt may match the same broadcast.
- Select: lowest-index entry with valid && rs.rdy && rt.rdy. Select uses state before the current edge's CDB capture.
- Output stage: loads when (!iss_valid || iss_ready) and a ready entry exists. The selected entry is removed and younger entries shift down one index on the same edge.
  - If iss_valid && !iss_ready, the output register holds all fields stable and no entry leaves.
  - iss_valid drops after acceptance when nothing is ready.
- Latency: op dispatched with both sources ready on edge E → iss_valid=1 in the cycle after edge E+1 (2 edges). One issue per cycle maximum, giving back-to-back throughput when iss_ready=1.
- Simultaneous dispatch and issue on the same edge: removal and compaction happen first, then the new op is written at the new tail; iq_count unchanged. Full queue with issue: disp_ready still 0 that cycle.
- Ops are never reordered except by readiness; ties always go to the older entry.

Optional Feature:
- Macro: IQ_PERF_CNT_EN.
- Defined: adds output perf_stall_cnt [15:0], counting cycles with disp_valid && !disp_ready. It saturates at 16'hFFFF, is cleared by rst, and is not cleared by flush.
- Undefined: port and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Ready op: dispatch ADD rs=5, rt=7, rd_tag=3 with both rdy → iss_valid 2 edges later, opcode=0000, rsdata=5, rtdata=7, rdtag=3; iq_count returns to 0.
- Wakeup and ordering: dispatch SUB with rs waiting on tag 9, then AND fully ready → AND issues first. A CDB broadcast of tag 9 with data 0x10 → SUB issues next with rsdata=0x10.
- Full/backpressure: iss_ready=0; dispatch 5 ready ops with DEPTH=4 → one op in the output register and 4 queued. disp_ready=0 and the op blocked by it stays pending; output fields stay stable until iss_ready=1. Then one op issues per cycle in dispatch order.
- Dispatch-time bypass: dispatch with rt_tag=12 not ready while the same cycle carries cdb tag 12, data 0xABCD → issues with rtdata=0xABCD, no hang.
- Flush mid-operation: 3 entries queued and iss_valid=1, plus a same-cycle dispatch, then assert flush → next cycle iss_valid=0, iq_count=0, disp_ready=1, and the dispatched op is discarded.
- Perf counter (IQ_PERF_CNT_EN): hold a full queue with disp_valid=1 for 10 cycles → perf_stall_cnt=10.

Source files
------------

// File: rtl/issue_queue_int.sv
// Integer issue queue: compacting reservation station with CDB snoop, oldest-ready select and a registered issue stage.
// Optional IQ_PERF_CNT_EN adds perf_stall_cnt, a saturating count of cycles where dispatch is stalled by a full queue.
module issue_queue_int #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [3:0]                 disp_opcode,
    input  logic                       disp_rs_rdy,
    input  logic [TAG_W-1:0]           disp_rs_tag,
    input  logic [DATA_W-1:0]          disp_rs_data,
    input  logic                       disp_rt_rdy,
    input  logic [TAG_W-1:0]           disp_rt_tag,
    input  logic [DATA_W-1:0]          disp_rt_data,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [3:0]                 iss_opcode,
    output logic [DATA_W-1:0]          iss_rsdata,
    output logic [DATA_W-1:0]          iss_rtdata,
    output logic [TAG_W-1:0]           iss_rdtag,
    output logic [$clog2(DEPTH+1)-1:0] iq_count
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [15:0]                perf_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              vld;
        logic [3:0]        op;
        logic [TAG_W-1:0]  rd;
        logic              rs_rdy;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rs_data;
        logic              rt_rdy;
        logic [TAG_W-1:0]  rt_tag;
        logic [DATA_W-1:0] rt_data;
    } entry_t;

    entry_t            r_q [DEPTH];
    logic [CW-1:0]     r_count;
    logic              r_iss_valid;
    logic [3:0]        r_iss_op;
    logic [DATA_W-1:0] r_iss_rs;
    logic [DATA_W-1:0] r_iss_rt;
    logic [TAG_W-1:0]  r_iss_rd;

    entry_t            w_cap [DEPTH+1];
    entry_t            w_nxt [DEPTH];
    entry_t            w_new;
    entry_t            w_sel_e;
    logic              w_any;
    logic [IW-1:0]     w_sel;
    logic              w_load;
    logic              w_acc;
    logic [CW-1:0]     w_tail;

    assign disp_ready = (r_count < CW'(DEPTH));
    assign w_acc      = disp_valid && disp_ready;
    assign w_load     = w_any && (!r_iss_valid || iss_ready);
    assign w_tail     = r_count - CW'(w_load);
    assign w_sel_e    = r_q[w_sel];

    // Select looks at pre-capture state, so a CDB wakeup costs one extra edge.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_q[i].vld && r_q[i].rs_rdy && r_q[i].rt_rdy) begin
                w_any = 1'b1;
                w_sel = IW'(i);
            end
        end
    end

    // Slot DEPTH is a permanently empty entry shifted in at the top on removal.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_cap[i] = r_q[i];
            if (cdb_valid && !r_q[i].rs_rdy && (r_q[i].rs_tag == cdb_tag)) begin
                w_cap[i].rs_rdy  = 1'b1;
                w_cap[i].rs_data = cdb_data;
            end
            if (cdb_valid && !r_q[i].rt_rdy && (r_q[i].rt_tag == cdb_tag)) begin
                w_cap[i].rt_rdy  = 1'b1;
                w_cap[i].rt_data = cdb_data;
            end
        end
        w_cap[DEPTH] = '0;
    end

    always_comb begin
        w_new         = '0;
        w_new.vld     = 1'b1;
        w_new.op      = disp_opcode;
        w_new.rd      = disp_rd_tag;
        w_new.rs_tag  = disp_rs_tag;
        w_new.rs_rdy  = disp_rs_rdy;
        w_new.rs_data = disp_rs_data;
        w_new.rt_tag  = disp_rt_tag;
        w_new.rt_rdy  = disp_rt_rdy;
        w_new.rt_data = disp_rt_data;
        if (!disp_rs_rdy && cdb_valid && (disp_rs_tag == cdb_tag)) begin
            w_new.rs_rdy  = 1'b1;
            w_new.rs_data = cdb_data;
        end
        if (!disp_rt_rdy && cdb_valid && (disp_rt_tag == cdb_tag)) begin
            w_new.rt_rdy  = 1'b1;
            w_new.rt_data = cdb_data;
        end
    end

    // Removal and compaction first, then the new op lands at the post-removal tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = (w_load && (i >= int'(w_sel))) ? w_cap[i+1] : w_cap[i];
            if (w_acc && (w_tail == CW'(i))) begin
                w_nxt[i] = w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count     <= '0;
            r_iss_valid <= 1'b0;
            r_iss_op    <= '0;
            r_iss_rs    <= '0;
            r_iss_rt    <= '0;
            r_iss_rd    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nxt[i];
            end
            r_count <= r_count + CW'(w_acc) - CW'(w_load);
            if (w_load) begin
                r_iss_valid <= 1'b1;
                r_iss_op    <= w_sel_e.op;
                r_iss_rs    <= w_sel_e.rs_data;
                r_iss_rt    <= w_sel_e.rt_data;
                r_iss_rd    <= w_sel_e.rd;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

    assign iss_valid  = r_iss_valid;
    assign iss_opcode = r_iss_op;
    assign iss_rsdata = r_iss_rs;
    assign iss_rtdata = r_iss_rt;
    assign iss_rdtag  = r_iss_rd;
    assign iq_count   = r_count;

`ifdef IQ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    // Survives flush so stalls around mispredicts stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (disp_valid && !disp_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_issue_queue_int.sv
// Bench for issue_queue_int: directed dispatch/CDB stimulus, issue scoreboard checked by an independent monitor.
// Build with IQ_PERF_CNT_EN defined to also exercise perf_stall_cnt.
module tb_issue_queue_int;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              disp_valid = 1'b0;
    logic              disp_ready;
    logic [3:0]        disp_opcode = '0;
    logic              disp_rs_rdy = 1'b0;
    logic [TAG_W-1:0]  disp_rs_tag = '0;
    logic [DATA_W-1:0] disp_rs_data = '0;
    logic              disp_rt_rdy = 1'b0;
    logic [TAG_W-1:0]  disp_rt_tag = '0;
    logic [DATA_W-1:0] disp_rt_data = '0;
    logic [TAG_W-1:0]  disp_rd_tag = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              iss_valid;
    logic              iss_ready = 1'b0;
    logic [3:0]        iss_opcode;
    logic [DATA_W-1:0] iss_rsdata;
    logic [DATA_W-1:0] iss_rtdata;
    logic [TAG_W-1:0]  iss_rdtag;
    logic [2:0]        iq_count;
`ifdef IQ_PERF_CNT_EN
    logic [15:0]       perf_stall_cnt;
`endif

    issue_queue_int #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
        .disp_rs_rdy(disp_rs_rdy), .disp_rs_tag(disp_rs_tag), .disp_rs_data(disp_rs_data),
        .disp_rt_rdy(disp_rt_rdy), .disp_rt_tag(disp_rt_tag), .disp_rt_data(disp_rt_data),
        .disp_rd_tag(disp_rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
        .iss_rsdata(iss_rsdata), .iss_rtdata(iss_rtdata), .iss_rdtag(iss_rdtag),
        .iq_count(iq_count)
`ifdef IQ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] rs;
        logic [DATA_W-1:0] rt;
        logic [TAG_W-1:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_iss   = 0;

    // Handshake sampled on the falling edge; it completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            n_total++;
            n_iss++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL issue_unexpected got op=%0h rs=%0h rt=%0h rd=%0h",
                         iss_opcode, iss_rsdata, iss_rtdata, iss_rdtag);
            end else begin
                mon_e = exp_q.pop_front();
                if ({iss_opcode, iss_rsdata, iss_rtdata, iss_rdtag} !== mon_e) begin
                    n_bad++;
                    $display("FAIL issue_data got op=%0h rs=%0h rt=%0h rd=%0h want op=%0h rs=%0h rt=%0h rd=%0h",
                             iss_opcode, iss_rsdata, iss_rtdata, iss_rdtag,
                             mon_e.op, mon_e.rs, mon_e.rt, mon_e.rd);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    task automatic set_disp(input logic [3:0] op, input logic rsr, input logic [5:0] rstag,
                            input logic [31:0] rsd, input logic rtr, input logic [5:0] rttag,
                            input logic [31:0] rtd, input logic [5:0] rd);
        disp_opcode  = op;
        disp_rs_rdy  = rsr;
        disp_rs_tag  = rstag;
        disp_rs_data = rsd;
        disp_rt_rdy  = rtr;
        disp_rt_tag  = rttag;
        disp_rt_data = rtd;
        disp_rd_tag  = rd;
    endtask

    task automatic disp(input logic [3:0] op, input logic rsr, input logic [5:0] rstag,
                        input logic [31:0] rsd, input logic rtr, input logic [5:0] rttag,
                        input logic [31:0] rtd, input logic [5:0] rd);
        set_disp(op, rsr, rstag, rsd, rtr, rttag, rtd, rd);
        disp_valid = 1'b1;
        chk("disp_ready_before_dispatch", {31'd0, disp_ready}, 32'd1);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin
            tick();
            c++;
        end
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout got pending=%0d want pending=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("rst_iq_count", {29'd0, iq_count}, 32'd0);
        chk("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("rst_iss_opcode", {28'd0, iss_opcode}, 32'd0);

        // single ready op: two edges to the output register
        iss_ready = 1'b1;
        exp_q.push_back('{op: 4'h0, rs: 32'd5, rt: 32'd7, rd: 6'd3});
        disp(4'h0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd3);
        chk("t1_count_after_disp", {29'd0, iq_count}, 32'd1);
        chk("t1_not_yet_valid", {31'd0, iss_valid}, 32'd0);
        tick();
        chk("t1_iss_valid", {31'd0, iss_valid}, 32'd1);
        chk("t1_iss_opcode", {28'd0, iss_opcode}, 32'd0);
        chk("t1_iss_rsdata", iss_rsdata, 32'd5);
        chk("t1_iss_rtdata", iss_rtdata, 32'd7);
        chk("t1_iss_rdtag", {26'd0, iss_rdtag}, 32'd3);
        chk("t1_count_zero", {29'd0, iq_count}, 32'd0);
        tick();
        chk("t1_valid_drops", {31'd0, iss_valid}, 32'd0);

        // wakeup and ordering: ready AND overtakes waiting SUB
        exp_q.push_back('{op: 4'h2, rs: 32'h3, rt: 32'h6, rd: 6'd5});
        exp_q.push_back('{op: 4'h1, rs: 32'h10, rt: 32'h2, rd: 6'd4});
        disp(4'h1, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h2, 6'd4);
        disp(4'h2, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 32'h6, 6'd5);
        tick();
        chk("t2_and_first", {28'd0, iss_opcode}, 32'h2);
        tick();
        chk("t2_sub_waits_valid", {31'd0, iss_valid}, 32'd0);
        chk("t2_sub_waits_count", {29'd0, iq_count}, 32'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        cdb_data  = 32'h10;
        tick();
        cdb_valid = 1'b0;
        tick();
        chk("t2_sub_valid", {31'd0, iss_valid}, 32'd1);
        chk("t2_sub_rsdata", iss_rsdata, 32'h10);
        drain(5);

        // full queue with backpressure, then back-to-back issue in order
        iss_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back('{op: 4'(i), rs: 32'h100 + 32'(i), rt: 32'h200 + 32'(i), rd: 6'(10 + i)});
        end
        for (int i = 1; i <= 5; i++) begin
            disp(4'(i), 1'b1, 6'd0, 32'h100 + 32'(i), 1'b1, 6'd0, 32'h200 + 32'(i), 6'(10 + i));
        end
        set_disp(4'd6, 1'b1, 6'd0, 32'h106, 1'b1, 6'd0, 32'h206, 6'd16);
        disp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_full_disp_ready", {31'd0, disp_ready}, 32'd0);
            chk("t3_full_count", {29'd0, iq_count}, 32'd4);
            chk("t3_hold_opcode", {28'd0, iss_opcode}, 32'd1);
            chk("t3_hold_rsdata", iss_rsdata, 32'h101);
            chk("t3_hold_rdtag", {26'd0, iss_rdtag}, 32'd11);
            tick();
        end
        base = n_iss;
        iss_ready = 1'b1;
        tick();
        chk("t3_next_loaded", {28'd0, iss_opcode}, 32'd2);
        chk("t3_disp_ready_reopens", {31'd0, disp_ready}, 32'd1);
        tick();
        disp_valid = 1'b0;
        repeat (4) tick();
        chk("t3_back_to_back", 32'(n_iss - base), 32'd6);
        chk("t3_valid_drops", {31'd0, iss_valid}, 32'd0);
        drain(3);

        // dispatch-time CDB bypass
        exp_q.push_back('{op: 4'h3, rs: 32'h1, rt: 32'hABCD, rd: 6'd7});
        cdb_valid = 1'b1;
        cdb_tag   = 6'd12;
        cdb_data  = 32'hABCD;
        disp(4'h3, 1'b1, 6'd0, 32'h1, 1'b0, 6'd12, 32'h0, 6'd7);
        cdb_valid = 1'b0;
        drain(10);
        chk("t4_count_zero", {29'd0, iq_count}, 32'd0);

        // flush with a same-cycle dispatch
        iss_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            disp(4'(i), 1'b1, 6'd0, 32'h500 + 32'(i), 1'b1, 6'd0, 32'h600 + 32'(i), 6'(20 + i));
        end
        chk("t5_pre_valid", {31'd0, iss_valid}, 32'd1);
        chk("t5_pre_count", {29'd0, iq_count}, 32'd3);
        set_disp(4'h9, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h88, 6'd30);
        disp_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        chk("t5_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("t5_count", {29'd0, iq_count}, 32'd0);
        chk("t5_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("t5_opcode_zero", {28'd0, iss_opcode}, 32'd0);
        chk("t5_rsdata_zero", iss_rsdata, 32'd0);
        iss_ready = 1'b1;
        repeat (3) tick();
        chk("t5_stays_empty", {29'd0, iq_count}, 32'd0);
        chk("t5_no_issue", {31'd0, iss_valid}, 32'd0);

`ifdef IQ_PERF_CNT_EN
        // stall counter over a held full queue
        iss_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            disp(4'(i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i), 6'(i));
        end
        chk("t6_full", {31'd0, disp_ready}, 32'd0);
        base = int'(perf_stall_cnt);
        disp_valid = 1'b1;
        repeat (10) tick();
        disp_valid = 1'b0;
        chk("t6_perf_stall_cnt", 32'(int'(perf_stall_cnt) - base), 32'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_not_cleared_by_flush", 32'(int'(perf_stall_cnt) - base), 32'd10);
        iss_ready = 1'b1;
`endif

        repeat (2) tick();
        chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
